bf_io_uart: RTL

- Memory-mapped-free I/O responder for the bfcpu io port. It turns CPU `.` writes into UART transmit bytes and CPU `,` reads into UART receive bytes.
- It sits in a board top next to the bfcpu, i_mem and d_mem instances, and replaces the LED stub as the io_req/io_ack responder.
- Reads block until a byte has been received. Writes block until the transmitter is free.

---
 rtl/bf_io_uart.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/bf_io_uart.sv
// bfcpu io-port responder: '.' writes become UART TX frames, ',' reads return UART RX bytes.
// Define UART_RX_FIFO_EN to replace the single RX holding register with a circular FIFO.
`ifndef DIRECTION_WRITE
`define DIRECTION_WRITE 1'b1
`endif

module bf_io_uart #(
  parameter int CLK_DIV            = 208,
  parameter int RX_FIFO_DEPTH_LOG2 = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       io_req,
  input  logic       io_dir,
  input  logic [7:0] io_wdata,
  output logic       io_ack,
  output logic [7:0] io_rdata,
  input  logic       uart_rx,
  output logic       uart_tx,
  output logic       rx_err
);
  localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLK_DIV / 2 - 1);

  typedef enum logic [1:0] {HS_IDLE, HS_XFER, HS_ACK} hs_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;

  hs_state_t   hs_state, hs_next;
  tx_state_t   tx_state, tx_next;
  rx_state_t   rx_state, rx_next;
  logic [15:0] tx_cnt, rx_cnt;
  logic [2:0]  tx_bit, rx_bit;
  logic [7:0]  tx_shift, rx_shift, rd_data;
  logic        rx_meta, rx_sync;
  logic        tx_start, rd_pop, rd_avail;
  logic        rx_push, rx_frame_err, rx_drop;
  logic        tx_tick, rx_tick, rx_half;

  assign tx_tick = (tx_cnt == DIV_LAST);
  assign rx_tick = (rx_cnt == DIV_LAST);
  assign rx_half = (rx_cnt == HALF_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) hs_state <= HS_IDLE;
    else        hs_state <= hs_next;
  end

  // A request withdrawn while still in XFER abandons the transfer without side effects.
  always_comb begin
    hs_next  = hs_state;
    tx_start = 1'b0;
    rd_pop   = 1'b0;
    case (hs_state)
      HS_IDLE: if (io_req) hs_next = HS_XFER;
      HS_XFER: begin
        if (!io_req) hs_next = HS_IDLE;
        else if (io_dir == `DIRECTION_WRITE) begin
          if (tx_state == TX_IDLE) begin
            tx_start = 1'b1;
            hs_next  = HS_ACK;
          end
        end else if (rd_avail) begin
          rd_pop  = 1'b1;
          hs_next = HS_ACK;
        end
      end
      HS_ACK:  if (!io_req) hs_next = HS_IDLE;
      default: hs_next = HS_IDLE;
    endcase
  end

  assign io_ack = (hs_state == HS_ACK);

  always_ff @(posedge clk) begin
    if (!rst_n)      io_rdata <= 8'h00;
    else if (rd_pop) io_rdata <= rd_data;
  end

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_IDLE:  if (tx_start) tx_next = TX_START;
      TX_START: if (tx_tick) tx_next = TX_DATA;
      TX_DATA:  if (tx_tick && tx_bit == 3'd7) tx_next = TX_STOP;
      TX_STOP:  if (tx_tick) tx_next = TX_IDLE;
      default:  tx_next = TX_IDLE;
    endcase
  end

  // uart_tx is registered and updated one step ahead so the line never glitches.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      uart_tx  <= 1'b1;
    end else begin
      tx_state <= tx_next;
      if (tx_state == TX_IDLE || tx_tick) tx_cnt <= '0;
      else                                tx_cnt <= tx_cnt + 16'd1;
      case (tx_state)
        TX_IDLE: if (tx_start) begin
          uart_tx <= 1'b0;
          tx_bit  <= '0;
        end
        TX_START: if (tx_tick) uart_tx <= tx_shift[0];
        TX_DATA: if (tx_tick) begin
          if (tx_bit != 3'd7) tx_bit <= tx_bit + 3'd1;
          uart_tx <= (tx_bit == 3'd7) ? 1'b1 : tx_shift[1];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (tx_start)                       tx_shift <= io_wdata;
    else if (tx_state == TX_DATA && tx_tick) tx_shift <= tx_shift >> 1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
    end
  end

  always_comb begin
    rx_next      = rx_state;
    rx_push      = 1'b0;
    rx_frame_err = 1'b0;
    case (rx_state)
      RX_IDLE:  if (!rx_sync) rx_next = RX_START;
      RX_START: if (rx_half) rx_next = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_tick && rx_bit == 3'd7) rx_next = RX_STOP;
      RX_STOP: if (rx_tick) begin
        if (rx_sync) begin
          rx_push = 1'b1;
          rx_next = RX_IDLE;
        end else begin
          rx_frame_err = 1'b1;
          rx_next      = RX_WAIT;
        end
      end
      RX_WAIT:  if (rx_sync) rx_next = RX_IDLE;
      default:  rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_err   <= 1'b0;
    end else begin
      rx_state <= rx_next;
      rx_err   <= rx_frame_err | rx_drop;
      if (rx_next != rx_state || rx_tick || rx_state == RX_IDLE || rx_state == RX_WAIT)
        rx_cnt <= '0;
      else
        rx_cnt <= rx_cnt + 16'd1;
      if (rx_state == RX_START) rx_bit <= '0;
      else if (rx_state == RX_DATA && rx_tick && rx_bit != 3'd7) rx_bit <= rx_bit + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rx_state == RX_DATA && rx_tick) rx_shift <= {rx_sync, rx_shift[7:1]};
  end

`ifdef UART_RX_FIFO_EN
  localparam int AW    = RX_FIFO_DEPTH_LOG2;
  localparam int DEPTH = 1 << AW;

  logic [7:0]  fifo_mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        fifo_full, fifo_empty, fifo_wr;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_avail   = !fifo_empty;
  assign rd_data    = fifo_mem[rd_ptr[AW-1:0]];
  assign fifo_wr    = rx_push && (!fifo_full || rd_pop);
  assign rx_drop    = rx_push && !fifo_wr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (fifo_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_wr) fifo_mem[wr_ptr[AW-1:0]] <= rx_shift;
  end
`else
  logic [7:0] hold_data;
  logic       hold_vld;
  logic       unused_depth;

  assign unused_depth = (RX_FIFO_DEPTH_LOG2 > 0);
  assign rd_avail     = hold_vld;
  assign rd_data      = hold_data;
  // A pop in the same cycle frees the register, so the new byte is accepted.
  assign rx_drop      = rx_push && hold_vld && !rd_pop;

  always_ff @(posedge clk) begin
    if (!rst_n)                   hold_vld <= 1'b0;
    else if (rx_push && !rx_drop) hold_vld <= 1'b1;
    else if (rd_pop)              hold_vld <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rx_push && !rx_drop) hold_data <= rx_shift;
  end
`endif

endmodule
